// File: rtl/aes_pkg.sv
// Shared AES helpers: round constants, GF(2^8) arithmetic, S-box byte, ShiftRows/MixColumns and FSM states.
// Byte ordering: bits[127:120] = state byte 0, bytes laid out column-major.
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_256 = 14;

    typedef logic [1:0] aes_state_t;
    localparam aes_state_t IDLE  = 2'd0;
    localparam aes_state_t ROUND = 2'd1;
    localparam aes_state_t DONE  = 2'd2;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = x;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Row r of column c takes the byte from column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] st);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(4*c+r) -: 8] = st[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/AES_Sbox.sv
// Four parallel AES S-box lookups on a 32-bit word.
module AES_Sbox
    import aes_pkg::*;
(
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);

    always_comb begin
        out_word = '0;
        for (int i = 0; i < 4; i++) begin
            out_word[8*i +: 8] = sbox_byte(in_word[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_step.sv
// One 128-bit key-expansion step: transform the last word, then chain XOR through the previous four words.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] prev_words,
    input  logic [31:0]  last_word,
    input  logic [7:0]   rcon_byte,
    input  logic         rot_en,
    output logic [127:0] next_words
);

    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] temp_word;
    logic [31:0] w0, w1, w2, w3;

    AES_Sbox u_sbox (
        .in_word  (rot_word),
        .out_word (sub_word)
    );

    always_comb begin
        rot_word   = rot_en ? {last_word[23:0], last_word[31:24]} : last_word;
        temp_word  = sub_word ^ {rcon_byte, 24'h000000};
        w0         = prev_words[127:96] ^ temp_word;
        w1         = prev_words[95:64]  ^ w0;
        w2         = prev_words[63:32]  ^ w1;
        w3         = prev_words[31:0]   ^ w2;
        next_words = {w0, w1, w2, w3};
    end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core, one round per clock, on-the-fly key expansion, valid/ready on both sides.
// KEY_BITS selects AES-128 (10 rounds) or AES-256 (14 rounds).
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        ip_text,
    input  logic [KEY_BITS-1:0] ip_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        op_cipher
);

    localparam int         NR     = (KEY_BITS == 256) ? NR_256 : NR_128;
    localparam logic [3:0] NR_CNT = 4'(NR);

    aes_state_t          state_q, state_d;
    logic [3:0]          rnd_cnt_q, rnd_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [127:0]        st_q, st_d;
    logic [KEY_BITS-1:0] kreg_q, kreg_d;
    logic [127:0]        op_cipher_q, op_cipher_d;

    logic                accept;
    logic                last_round;
    logic [127:0]        sub_bytes;
    logic [127:0]        shifted;
    logic [127:0]        mixed;
    logic [127:0]        round_key;
    logic [127:0]        round_out;
    logic [127:0]        step_out;
    logic [KEY_BITS-1:0] kreg_adv;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign op_cipher  = op_cipher_q;
    assign accept     = (state_q == IDLE) && in_valid;
    assign last_round = (state_q == ROUND) && (rnd_cnt_q == NR_CNT);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        AES_Sbox u_sbox (
            .in_word  (st_q[127-32*i -: 32]),
            .out_word (sub_bytes[127-32*i -: 32])
        );
    end

    if (KEY_BITS == 128) begin : g_key128
        aes_key_step u_key_step (
            .prev_words (kreg_q),
            .last_word  (kreg_q[31:0]),
            .rcon_byte  (rcon(rnd_cnt_q)),
            .rot_en     (1'b1),
            .next_words (step_out)
        );
        assign round_key = step_out;
        assign kreg_adv  = step_out;
    end else if (KEY_BITS == 256) begin : g_key256
        // Window {A,B}: round 1 uses B as is; later rounds derive a new block from A and B's last word.
        aes_key_step u_key_step (
            .prev_words (kreg_q[255:128]),
            .last_word  (kreg_q[31:0]),
            .rcon_byte  (rnd_cnt_q[0] ? 8'h00 : rcon({1'b0, rnd_cnt_q[3:1]})),
            .rot_en     (~rnd_cnt_q[0]),
            .next_words (step_out)
        );
        assign round_key = (rnd_cnt_q == 4'd1) ? kreg_q[127:0] : step_out;
        assign kreg_adv  = (rnd_cnt_q == 4'd1) ? kreg_q : {kreg_q[127:0], step_out};
    end else begin : g_bad_key
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    always_comb begin
        shifted = shift_rows(sub_bytes);
        mixed   = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
        end
        round_out = (last_round ? shifted : mixed) ^ round_key;
    end

    always_comb begin
        state_d     = state_q;
        rnd_cnt_d   = rnd_cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rnd_cnt_d = 4'd1;
                    state_d   = ROUND;
                end
            end
            ROUND: begin
                if (last_round) begin
                    rnd_cnt_d   = 4'd0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    rnd_cnt_d = rnd_cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rnd_cnt_d   = 4'd0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_comb begin
        st_d        = st_q;
        kreg_d      = kreg_q;
        op_cipher_d = op_cipher_q;
        if (accept) begin
            st_d   = ip_text ^ ip_key[KEY_BITS-1 -: 128];
            kreg_d = ip_key;
        end else if (state_q == ROUND) begin
            st_d   = round_out;
            kreg_d = kreg_adv;
            if (last_round) op_cipher_d = round_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rnd_cnt_q   <= 4'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_cnt_q   <= rnd_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q        <= '0;
            kreg_q      <= '0;
            op_cipher_q <= '0;
        end else begin
            st_q        <= st_d;
            kreg_q      <= kreg_d;
            op_cipher_q <= op_cipher_d;
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: AES-128 and AES-256 instances checked against a byte-level FIPS-197 reference.
module tb_aes_iter_core;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] ip_text;
    logic         out_ready;

    logic         in_valid_a, in_ready_a, out_valid_a;
    logic [127:0] key_a, op_a;
    logic         in_valid_b, in_ready_b, out_valid_b;
    logic [255:0] key_b;
    logic [127:0] op_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] sbox_tab [256];

    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    always #5 clk = ~clk;

    aes_iter_core #(.KEY_BITS(128)) dut_128 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .ip_text   (ip_text),
        .ip_key    (key_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .op_cipher (op_a)
    );

    aes_iter_core #(.KEY_BITS(256)) dut_256 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .ip_text   (ip_text),
        .ip_key    (key_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .op_cipher (op_b)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        while (y != 0) begin
            if (y[0]) p ^= x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: brute-force inverse, then the affine map bit by bit.
    task automatic build_sbox();
        logic [7:0] inv, s;
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // key is left-aligned: a 128-bit key occupies bits [255:128].
    function automatic logic [127:0] ref_aes(input logic [127:0] text, input logic [255:0] key, input int kbits);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  temp;
        logic [7:0]   rc = 8'h01;
        logic [127:0] res;
        int nk = kbits / 32;
        int nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                temp = subw(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int i = 0; i < 16; i++) s[i] = text[127-8*i -: 8];
        for (int k = 0; k <= nr; k++) begin
            if (k > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
                for (int c = 0; c < 4; c++) begin
                    if (k < nr) begin
                        s[4*c+0] = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
                        s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
                        s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
                        s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
                    end else begin
                        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] ^= w[4*k+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ov_of(input bit wide);
        return {127'h0, wide ? out_valid_b : out_valid_a};
    endfunction

    function automatic logic [127:0] ir_of(input bit wide);
        return {127'h0, wide ? in_ready_b : in_ready_a};
    endfunction

    function automatic logic [127:0] op_of(input bit wide);
        return wide ? op_b : op_a;
    endfunction

    // Presents one block for a single accept edge, then scrambles the inputs.
    task automatic applyStimulus(input bit wide, input logic [127:0] text, input logic [255:0] key);
        checkOutput("ready_before_accept", ir_of(wide), 128'h1);
        ip_text = text;
        key_a   = key[255:128];
        key_b   = key;
        if (wide) in_valid_b = 1'b1;
        else      in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        ip_text    = {$urandom, $urandom, $urandom, $urandom};
        key_a      = {$urandom, $urandom, $urandom, $urandom};
        key_b      = {key_a, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic waitResult(input bit wide, output int lat);
        lat = 0;
        while (ov_of(wide) != 128'h1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain(input bit wide);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("drain_valid_low", ov_of(wide), 128'h0);
        checkOutput("drain_ready_high", ir_of(wide), 128'h1);
    endtask

    task automatic runBlock(input bit wide, input logic [127:0] text, input logic [255:0] key);
        int lat;
        applyStimulus(wide, text, key);
        waitResult(wide, lat);
        checkOutput("latency", 128'(lat), wide ? 128'd14 : 128'd10);
        checkOutput("cipher_model", op_of(wide), ref_aes(text, key, wide ? 256 : 128));
    endtask

    initial begin
        int lat;
        logic [127:0] exp_ct;
        logic [127:0] rt;
        logic [255:0] rk;

        build_sbox();
        reset = 1'b0;  out_ready = 1'b0; ip_text = '0;
        in_valid_a = 1'b0; in_valid_b = 1'b0; key_a = '0; key_b = '0;
        tick();
        tick();
        checkOutput("rst_valid_128", ov_of(0), 128'h0);
        checkOutput("rst_cipher_128", op_a, 128'h0);
        checkOutput("rst_valid_256", ov_of(1), 128'h0);
        checkOutput("rst_cipher_256", op_b, 128'h0);
        reset = 1'b1;
        tick();
        checkOutput("rst_ready_128", ir_of(0), 128'h1);
        checkOutput("rst_ready_256", ir_of(1), 128'h1);

        $display("[TB] vectors 1-3");
        runBlock(0, PT1, {K1, 128'h0});
        checkOutput("vec1_literal", op_a, CT1);
        drain(0);
        runBlock(0, PT2, {K2, 128'h0});
        checkOutput("vec2_literal", op_a, CT2);
        drain(0);
        runBlock(1, PT1, K3);
        checkOutput("vec3_literal", op_b, CT3);
        drain(1);

        $display("[TB] back-pressure");
        runBlock(0, PT2, {K2, 128'h0});
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("bp_valid", ov_of(0), 128'h1);
            checkOutput("bp_cipher", op_a, CT2);
            checkOutput("bp_ready", ir_of(0), 128'h0);
        end
        drain(0);

        $display("[TB] busy input");
        applyStimulus(0, PT1, {K1, 128'h0});
        repeat (4) tick();
        in_valid_a = 1'b1;
        ip_text    = PT2;
        key_a      = K2;
        checkOutput("busy_ready_low", ir_of(0), 128'h0);
        tick();
        in_valid_a = 1'b0;
        waitResult(0, lat);
        checkOutput("busy_latency", 128'(lat + 5), 128'd10);
        checkOutput("busy_cipher", op_a, CT1);
        drain(0);

        $display("[TB] reset mid-block");
        applyStimulus(0, PT2, {K2, 128'h0});
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("midrst_valid", ov_of(0), 128'h0);
        checkOutput("midrst_cipher", op_a, 128'h0);
        checkOutput("midrst_ready", ir_of(0), 128'h1);
        runBlock(0, PT1, {K1, 128'h0});
        checkOutput("midrst_vec1", op_a, CT1);
        drain(0);

        $display("[TB] random blocks");
        for (int n = 0; n < 6; n++) begin
            rt = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (n % 2 == 0) rk[127:0] = '0;
            runBlock(n % 2 == 1, rt, rk);
            exp_ct = ref_aes(rt, rk, (n % 2 == 1) ? 256 : 128);
            tick();
            checkOutput("rand_hold", op_of(n % 2 == 1), exp_ct);
            drain(n % 2 == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
